mapa_arbiter: RTL and testbench

Arbitrates the single-port map RAM (one 4-bit cell per grid position) between the VGA renderer, which is read-only, and the game update logic, which reads and writes. It converts (x, y) grid coordinates into linear RAM addresses and pipelines the RAM accesses. It also provides a lock so that the game logic's read-then-write of a cell (for example, read tail direction, then clear tail) is atomic with respect to the renderer. It sits between the renderer, the update logic and the map RAM instance.

---
 rtl/mapa_arbiter.sv | 146 ++++++++++++++
 tb/tb_mapa_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mapa_arbiter.sv
// Map RAM arbiter: renderer (read-only) vs game logic (read/write), with lock for atomic read-modify-write.
// Optional forced game grant after STARVE_MAX denied cycles when MAPA_ARB_STARVE_EN is defined.
module mapa_arbiter #(
  parameter int MAPA_WIDTH  = 32,
  parameter int MAPA_HEIGHT = 24,
  parameter int ADDR_W      = 10,
  parameter int STARVE_MAX  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [4:0]        vid_x,
  input  logic [4:0]        vid_y,
  output logic              vid_gnt,
  output logic              vid_valid,
  output logic [3:0]        vid_dado,
  input  logic              game_req,
  input  logic              game_we,
  input  logic              game_lock,
  input  logic [4:0]        game_x,
  input  logic [4:0]        game_y,
  input  logic [3:0]        game_dado_w,
  output logic              game_gnt,
  output logic              game_valid,
  output logic [3:0]        game_dado_r,
  output logic              game_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_wdata,
  input  logic [3:0]        ram_rdata
);

  if ((2 ** ADDR_W) < MAPA_WIDTH * MAPA_HEIGHT || STARVE_MAX < 1) begin : g_param_check
    $error("mapa_arbiter: ADDR_W too small for the grid or STARVE_MAX < 1");
  end

  typedef enum logic {ARB, LOCKED} state_t;

  state_t state, state_nx;

  function automatic logic in_range(input logic [4:0] x, input logic [4:0] y);
    return (32'(x) < 32'(MAPA_WIDTH)) && (32'(y) < 32'(MAPA_HEIGHT));
  endfunction

  function automatic logic [ADDR_W-1:0] lin_addr(input logic [4:0] x, input logic [4:0] y);
    logic [31:0] full;
    full = 32'(y) * 32'(MAPA_WIDTH) + 32'(x);
    return full[ADDR_W-1:0];
  endfunction

  logic force_game;

`ifdef MAPA_ARB_STARVE_EN
  localparam int CNT_W = ($clog2(STARVE_MAX + 1) < 3) ? 3 : $clog2(STARVE_MAX + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  logic [CNT_W-1:0] starve_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve_cnt <= '0;
    else if (game_req && !game_gnt)
      starve_cnt <= sat_inc(starve_cnt);
    else
      starve_cnt <= '0;
  end

  assign force_game = (starve_cnt >= CNT_W'(STARVE_MAX));
`else
  assign force_game = 1'b0;
`endif

  // Grant decision and lock tracking; grants are combinational so a held request is accepted this cycle
  always_comb begin
    vid_gnt  = 1'b0;
    game_gnt = 1'b0;
    state_nx = state;
    case (state)
      ARB: begin
        if (game_req && (force_game || !vid_req))
          game_gnt = 1'b1;
        else if (vid_req)
          vid_gnt = 1'b1;
        if (game_gnt && game_lock)
          state_nx = LOCKED;
      end
      LOCKED: begin
        game_gnt = game_req;
        if (!game_lock)
          state_nx = ARB;
      end
      default: state_nx = ARB;
    endcase
  end

  logic       gnt_any;
  logic [4:0] sel_x, sel_y;
  logic       sel_ok;

  assign gnt_any = vid_gnt | game_gnt;
  assign sel_x   = game_gnt ? game_x : vid_x;
  assign sel_y   = game_gnt ? game_y : vid_y;
  assign sel_ok  = in_range(sel_x, sel_y);

  // Stage p1: RAM command registers
  logic vid_vld_p1, game_vld_p1, oor_p1, oor_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB;
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_wdata   <= '0;
      game_err    <= 1'b0;
      vid_vld_p1  <= 1'b0;
      game_vld_p1 <= 1'b0;
      vid_valid   <= 1'b0;
      game_valid  <= 1'b0;
    end else begin
      state       <= state_nx;
      if (gnt_any)
        ram_addr <= lin_addr(sel_x, sel_y);
      if (game_gnt && game_we)
        ram_wdata <= game_dado_w;
      ram_we      <= game_gnt & game_we & sel_ok;
      game_err    <= game_gnt & ~sel_ok;
      vid_vld_p1  <= vid_gnt;
      game_vld_p1 <= game_gnt & ~game_we;
      vid_valid   <= vid_vld_p1;
      game_valid  <= game_vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    oor_p1 <= ~sel_ok;
    oor_p2 <= oor_p1;
  end

  // Stage p2: RAM output register read through, zeroed for out-of-range cells
  assign vid_dado    = (vid_valid && !oor_p2) ? ram_rdata : 4'h0;
  assign game_dado_r = (game_valid && !oor_p2) ? ram_rdata : 4'h0;

endmodule

// File: tb/tb_mapa_arbiter.sv
// Directed bench for mapa_arbiter with a behavioural synchronous map RAM.
module tb_mapa_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vid_req, game_req, game_we, game_lock;
  logic [4:0] vid_x, vid_y, game_x, game_y;
  logic [3:0] game_dado_w;
  logic       vid_gnt, vid_valid, game_gnt, game_valid, game_err, ram_we;
  logic [3:0] vid_dado, game_dado_r, ram_wdata, ram_rdata;
  logic [9:0] ram_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mapa_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .vid_req(vid_req), .vid_x(vid_x), .vid_y(vid_y),
    .vid_gnt(vid_gnt), .vid_valid(vid_valid), .vid_dado(vid_dado),
    .game_req(game_req), .game_we(game_we), .game_lock(game_lock),
    .game_x(game_x), .game_y(game_y), .game_dado_w(game_dado_w),
    .game_gnt(game_gnt), .game_valid(game_valid), .game_dado_r(game_dado_r),
    .game_err(game_err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Behavioural RAM: write-first, 1-cycle read latency, every cell preset to 7 while in reset
  logic [3:0] mem [0:1023];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 4'h7;
      ram_rdata <= 4'h0;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_we ? ram_wdata : mem[ram_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    int vr, vx, vy, gr, gwe, glk, gx, gy, gd;
    int e_vg, e_gg, e_we, e_addr, e_vv, e_vd, e_gv, e_gd, e_err;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int vr, input int vx, input int vy, input int gr, input int gwe,
                       input int glk, input int gx, input int gy, input int gd);
    vid_req = vr[0]; vid_x = 5'(vx); vid_y = 5'(vy);
    game_req = gr[0]; game_we = gwe[0]; game_lock = glk[0];
    game_x = 5'(gx); game_y = 5'(gy); game_dado_w = 4'(gd);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vid_gnt"}, 32'(vid_gnt), 0);
    chk({tag, "_game_gnt"}, 32'(game_gnt), 0);
    chk({tag, "_vid_valid"}, 32'(vid_valid), 0);
    chk({tag, "_vid_dado"}, 32'(vid_dado), 0);
    chk({tag, "_game_valid"}, 32'(game_valid), 0);
    chk({tag, "_game_dado_r"}, 32'(game_dado_r), 0);
    chk({tag, "_game_err"}, 32'(game_err), 0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
    chk({tag, "_ram_we"}, 32'(ram_we), 0);
    chk({tag, "_ram_wdata"}, 32'(ram_wdata), 0);
  endtask

  initial begin
    int exp_vg, exp_gg, gr_now;
    bit granted;

    // vr vx vy gr we lk gx gy gd | vg gg we addr vv vd gv gd err
    vecs[0]  = '{0,0,0,  1,1,0, 3,2, 10,  0,1,0,  0,  0,0, 0, 0,0};
    vecs[1]  = '{0,0,0,  1,0,0, 3,2,  0,  0,1,1, 67,  0,0, 0, 0,0};
    vecs[2]  = '{0,0,0,  1,1,0, 5,1,  5,  0,1,0, 67,  0,0, 0, 0,0};
    vecs[3]  = '{1,5,1,  1,0,0, 0,0,  0,  1,0,1, 37,  0,0, 1,10,0};
    vecs[4]  = '{0,0,0,  1,0,0, 0,0,  0,  0,1,0, 37,  0,0, 0, 0,0};
    vecs[5]  = '{0,0,0,  1,1,0, 0,24,15,  0,1,0,  0,  1,5, 0, 0,0};
    vecs[6]  = '{1,3,24, 0,0,0, 0,0,  0,  1,0,0,768,  0,0, 1, 7,1};
    vecs[7]  = '{0,0,0,  0,0,0, 0,0,  0,  0,0,0,771,  0,0, 0, 0,0};
    vecs[8]  = '{0,0,0,  0,0,0, 0,0,  0,  0,0,0,771,  1,0, 0, 0,0};
    vecs[9]  = '{0,0,0,  1,0,0, 5,1,  0,  0,1,0,771,  0,0, 0, 0,0};
    vecs[10] = '{0,0,0,  0,0,0, 0,0,  0,  0,0,0, 37,  0,0, 0, 0,0};
    vecs[11] = '{0,0,0,  0,0,0, 0,0,  0,  0,0,0, 37,  0,0, 1, 5,0};

    rst_n = 1'b0;
    drive(0,0,0, 0,0,0, 0,0,0);
    repeat (3) next_cycle();
    #3;
    chk_all_zero("reset");
    next_cycle();
    rst_n = 1'b1;

    // Table: write/read, contention, out-of-range write and read
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      drive(vecs[i].vr, vecs[i].vx, vecs[i].vy, vecs[i].gr, vecs[i].gwe,
            vecs[i].glk, vecs[i].gx, vecs[i].gy, vecs[i].gd);
      #3;
      chk($sformatf("v%0d_vid_gnt", i), 32'(vid_gnt), vecs[i].e_vg);
      chk($sformatf("v%0d_game_gnt", i), 32'(game_gnt), vecs[i].e_gg);
      chk($sformatf("v%0d_ram_we", i), 32'(ram_we), vecs[i].e_we);
      chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), vecs[i].e_addr);
      chk($sformatf("v%0d_vid_valid", i), 32'(vid_valid), vecs[i].e_vv);
      chk($sformatf("v%0d_vid_dado", i), 32'(vid_dado), vecs[i].e_vd);
      chk($sformatf("v%0d_game_valid", i), 32'(game_valid), vecs[i].e_gv);
      chk($sformatf("v%0d_game_dado_r", i), 32'(game_dado_r), vecs[i].e_gd);
      chk($sformatf("v%0d_game_err", i), 32'(game_err), vecs[i].e_err);
    end

    // Lock: locked read of (3,2), renderer waiting, unlocking write
    next_cycle();
    drive(0,0,0, 1,0,1, 3,2,0);
    #3;
    chk("lock_c0_game_gnt", 32'(game_gnt), 1);
    chk("lock_c0_vid_gnt", 32'(vid_gnt), 0);
    next_cycle();
    drive(1,1,1, 0,0,1, 0,0,0);
    #3;
    chk("lock_c1_vid_gnt", 32'(vid_gnt), 0);
    chk("lock_c1_game_gnt", 32'(game_gnt), 0);
    next_cycle();
    drive(1,1,1, 1,1,0, 3,2,3);
    #3;
    chk("lock_c2_vid_gnt", 32'(vid_gnt), 0);
    chk("lock_c2_game_gnt", 32'(game_gnt), 1);
    chk("lock_c2_game_valid", 32'(game_valid), 1);
    chk("lock_c2_game_dado_r", 32'(game_dado_r), 10);
    next_cycle();
    drive(1,1,1, 0,0,0, 0,0,0);
    #3;
    chk("lock_c3_vid_gnt", 32'(vid_gnt), 1);
    next_cycle();
    drive(0,0,0, 0,0,0, 0,0,0);
    repeat (2) next_cycle();

    // Starvation: renderer requests continuously while the game waits
    granted = 1'b0;
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      gr_now = granted ? 0 : 1;
      drive(1,1,1, gr_now,0,0, 0,0,0);
`ifdef MAPA_ARB_STARVE_EN
      exp_gg = (i == 8) ? 1 : 0;
`else
      exp_gg = 0;
`endif
      exp_vg = 1 - exp_gg;
      #3;
      chk($sformatf("starve%0d_game_gnt", i), 32'(game_gnt), exp_gg);
      chk($sformatf("starve%0d_vid_gnt", i), 32'(vid_gnt), exp_vg);
      if (game_gnt) granted = 1'b1;
    end
    next_cycle();
    drive(0,0,0, 0,0,0, 0,0,0);
    repeat (3) next_cycle();

    // Mid-read reset: video read granted, then lock taken and reset during its p1 cycle
    next_cycle();
    drive(1,3,2, 0,0,0, 0,0,0);
    #3;
    chk("rst_c0_vid_gnt", 32'(vid_gnt), 1);
    next_cycle();
    drive(0,0,0, 1,0,1, 0,0,0);
    #1;
    chk("rst_c1_game_gnt", 32'(game_gnt), 1);
    drive(0,0,0, 0,0,0, 0,0,0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    next_cycle();
    #3;
    chk("midrst_c2_vid_valid", 32'(vid_valid), 0);
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      #3;
      chk($sformatf("postrst%0d_vid_valid", i), 32'(vid_valid), 0);
      chk($sformatf("postrst%0d_ram_addr", i), 32'(ram_addr), 0);
    end
    next_cycle();
    drive(1,1,1, 0,0,0, 0,0,0);
    #3;
    chk("postrst_vid_gnt_arb", 32'(vid_gnt), 1);
    next_cycle();
    drive(0,0,0, 0,0,0, 0,0,0);
    repeat (2) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
